multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control FSM for the multicycle MIPS datapath.
- Sequences one shared ALU, one shared memory port, the instruction register (IR) and the register file across several cycles per instruction.
- Decodes opcode/funct into per-state Moore control signals and waits on a memory-ready handshake.
- Counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access requested.
- mem_write  out  1  access is a write.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- ir_write  out  1  load IR.
- pc_en  out  1  PC load enable.
- pc_src  out  2  next PC select: 00=ALU result, 01=ALUOut, 10=jump target.
- alu_src_a  out  1  0=PC, 1=A register.
- alu_src_b  out  2  00=B, 01=constant 4, 10=SignImm, 11=SignImm<<2.
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- reg_dst  out  1  1=rd, 0=rt.
- memto_reg  out  1  1=data register, 0=ALUOut.
- reg_write  out  1  register file write enable.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode or funct.
- state_o  out  4  current state, for debug.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Single clock domain clk. Synchronous active-high reset: state goes to FETCH, retired goes to 0, illegal_op goes to 0. While reset is high, every enable output is forced to 0: mem_req, mem_write, ir_write, pc_en, reg_write.
- All control outputs are combinational from the state register (Moore). The only exceptions are pc_en, ir_write and the illegal_op decode, which also depend on inputs as listed below.
- Any output not listed for a state is 0.

States and outputs:
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu op add, pc_src=00.
  - ir_write=mem_ready and pc_en=mem_ready.
  - Stays in FETCH while mem_ready=0; moves to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, add (precomputes the branch target). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other opcode -> FETCH, with illegal_op=1 for this cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, add. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Waits for mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, memto_reg=1. Next state FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. Waits for mem_ready, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_control from funct:
  - 100000 -> add (010)
  - 100010 -> sub (110)
  - 100100 -> and (000)
  - 100101 -> or (001)
  - 101010 -> slt (111)
  - any other funct -> add (010) plus an illegal_op pulse; the instruction still proceeds to ALUWB.
  - Next state ALUWB.
- ALUWB: reg_write=1, reg_dst=1, memto_reg=0. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=zero. Next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add. Next state ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, memto_reg=0. Next state FETCH.
- JUMP: pc_src=10, pc_en=1. Next state FETCH.

Latency with mem_ready held at 1 (cycles from entering FETCH back to FETCH):
- lw 5
- sw 4
- R-type 4
- addi 4
- beq 3
- j 3
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.

mem_ready rules:
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.
- mem_req stays asserted and iord/mem_write stay stable until the completing cycle.

retired counter:
- Increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP.
- Does not increment on the illegal-opcode exit from DECODE.
- Wraps from 2^CNT_W-1 to 0.

Reset mid-operation:
- Takes priority over every transition.
- No write enable is asserted in the reset cycle, including a MEMWR cycle with mem_ready=1.
- An in-flight access is simply abandoned.

Decomposition:
- Package mc_pkg holds:
  - state_t enum (4-bit): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - Funct constants.
  - ALU control constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT.
- One sub-module, mc_alu_decoder: combinational mapping {alu_op[1:0], funct} -> {alu_control, funct_illegal}.
- The FSM itself stays in the top module.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 and opcode=100011 (lw): state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; reg_write=1 only in MEMWB, with memto_reg=1 and reg_dst=0; retired=1.
- sw with mem_ready low for 3 cycles in MEMWR: mem_req=1 and mem_write=1 held for 4 cycles; leaves MEMWR on the first mem_ready=1 cycle; total latency 7 cycles.
- beq with zero=1, then beq with zero=0: pc_en=1 with pc_src=01 in BRANCH only in the first case; both take 3 cycles; retired increments by 2.
- R-type with funct=101010, then funct=111111: alu_control=111 in EXECUTE for the first; for the second, alu_control=010 with a 1-cycle illegal_op pulse in EXECUTE, then ALUWB writes.
- opcode=111111 in DECODE: illegal_op=1 for one cycle, next state FETCH, no write enables asserted, retired unchanged.
- CNT_W=4, retire 17 j instructions: retired reads 15 then 0 then 1. Assert reset during MEMWR with mem_ready=1: mem_write=0 that cycle, next state FETCH, retired=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// Opcode, funct and ALU control values follow the classic MIPS encodings.
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Internal FSM-to-decoder ALU operation class.
   localparam logic [1:0] AOP_ADD   = 2'b00;
   localparam logic [1:0] AOP_SUB   = 2'b01;
   localparam logic [1:0] AOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps the FSM's ALU operation class plus funct to an ALU control code.
// Unsupported functs fall back to add and raise funct_illegal.
module mc_alu_decoder
   import mc_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [2:0] alu_control,
   output logic       funct_illegal
);

   always_comb begin
      alu_control   = ALU_ADD;
      funct_illegal = 1'b0;
      case (alu_op)
         AOP_SUB:   alu_control = ALU_SUB;
         AOP_FUNCT: begin
            case (funct)
               FN_ADD:  alu_control = ALU_ADD;
               FN_SUB:  alu_control = ALU_SUB;
               FN_AND:  alu_control = ALU_AND;
               FN_OR:   alu_control = ALU_OR;
               FN_SLT:  alu_control = ALU_SLT;
               default: funct_illegal = 1'b1;
            endcase
         end
         default:   alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath: Moore control outputs per state,
// memory-ready handshake in FETCH/MEMRD/MEMWR, and a retired-instruction counter.
module multicycle_controller
   import mc_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_write,
   output logic             iord,
   output logic             ir_write,
   output logic             pc_en,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_control,
   output logic             reg_dst,
   output logic             memto_reg,
   output logic             reg_write,
   output logic             illegal_op,
   output logic [3:0]       state_o,
   output logic [CNT_W-1:0] retired
);

   state_t     state, state_nx;
   logic [1:0] alu_op;
   logic       funct_illegal;
   logic       op_illegal;
   logic       retire;

   mc_alu_decoder u_alu_dec (
      .alu_op        (alu_op),
      .funct         (funct),
      .alu_control   (alu_control),
      .funct_illegal (funct_illegal)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= FETCH;
         retired <= '0;
      end else begin
         state <= state_nx;
         if (retire) retired <= retired + CNT_W'(1);
      end
   end

   always_comb begin
      state_nx   = state;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = AOP_ADD;
      reg_dst    = 1'b0;
      memto_reg  = 1'b0;
      reg_write  = 1'b0;
      op_illegal = 1'b0;
      retire     = 1'b0;
      case (state)
         FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_en     = mem_ready;
            if (mem_ready) state_nx = DECODE;
         end
         DECODE: begin
            // Branch target is computed here so BRANCH only has to compare.
            alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_nx = MEMADR;
               OP_RTYPE:     state_nx = EXECUTE;
               OP_BEQ:       state_nx = BRANCH;
               OP_ADDI:      state_nx = ADDIEX;
               OP_J:         state_nx = JUMP;
               default: begin
                  state_nx   = FETCH;
                  op_illegal = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_nx  = (opcode == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) state_nx = MEMWB;
         end
         MEMWB: begin
            reg_write = 1'b1;
            memto_reg = 1'b1;
            state_nx  = FETCH;
            retire    = 1'b1;
         end
         MEMWR: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) begin
               state_nx = FETCH;
               retire   = 1'b1;
            end
         end
         EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = AOP_FUNCT;
            state_nx  = ALUWB;
         end
         ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_nx  = FETCH;
            retire    = 1'b1;
         end
         BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = AOP_SUB;
            pc_src    = 2'b01;
            pc_en     = zero;
            state_nx  = FETCH;
            retire    = 1'b1;
         end
         ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_nx  = ADDIWB;
         end
         ADDIWB: begin
            reg_write = 1'b1;
            state_nx  = FETCH;
            retire    = 1'b1;
         end
         JUMP: begin
            pc_src   = 2'b10;
            pc_en    = 1'b1;
            state_nx = FETCH;
            retire   = 1'b1;
         end
         default: state_nx = FETCH;
      endcase
      // Reset abandons any in-flight access, so no enable may escape this cycle.
      if (reset) begin
         mem_req   = 1'b0;
         mem_write = 1'b0;
         ir_write  = 1'b0;
         pc_en     = 1'b0;
         reg_write = 1'b0;
      end
   end

   assign illegal_op = !reset && (op_illegal || funct_illegal);
   assign state_o    = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per-instruction expectations from a behavioural model are
// queued by the stimulus and compared by a monitor at each return to FETCH.
module tb_multicycle_controller;
   import mc_pkg::*;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [5:0]       opcode, funct;
   logic             zero, mem_ready;
   logic             mem_req, mem_write, iord, ir_write, pc_en;
   logic [1:0]       pc_src, alu_src_b;
   logic             alu_src_a, reg_dst, memto_reg, reg_write, illegal_op;
   logic [2:0]       alu_control;
   logic [3:0]       state_o;
   logic [CNT_W-1:0] retired;

   multicycle_controller #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
      .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_control(alu_control), .reg_dst(reg_dst),
      .memto_reg(memto_reg), .reg_write(reg_write), .illegal_op(illegal_op),
      .state_o(state_o), .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lat, ret, n_mreq, n_iord, n_mw, n_irw, n_pcen, n_rw, n_ill;
      int pcs, alu, dst, m2r;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   ret_model = 0;
   bit   mon_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic mr);
      mem_ready = mr;
      @(posedge clk);
      #1;
   endtask

   // Reference ALU mapping for R-type functs.
   function automatic int alu_ref(input logic [5:0] fn, output bit bad);
      bad = 1'b0;
      case (fn)
         6'b100000: return 2;
         6'b100010: return 6;
         6'b100100: return 0;
         6'b100101: return 1;
         6'b101010: return 7;
         default: begin bad = 1'b1; return 2; end
      endcase
   endfunction

   // One instruction: fs fetch stall cycles, ms memory stall cycles (lw/sw only).
   task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input int fs, input int ms);
      exp_t e;
      bit   mem_op, bad;
      int   base;
      e = '{default: 0};
      mem_op = (op == 6'b100011) || (op == 6'b101011);
      e.n_irw  = 1;
      e.n_pcen = 1;
      e.n_mreq = fs + 1;
      base = 2;
      case (op)
         6'b100011: begin base = 5; e.n_mreq += ms + 1; e.n_iord = ms + 1;
                          e.n_rw = 1; e.m2r = 1; end
         6'b101011: begin base = 4; e.n_mreq += ms + 1; e.n_iord = ms + 1;
                          e.n_mw = ms + 1; end
         6'b000000: begin base = 4; e.n_rw = 1; e.dst = 1;
                          e.alu = alu_ref(fn, bad); e.n_ill = bad ? 1 : 0; end
         6'b001000: begin base = 4; e.n_rw = 1; end
         6'b000100: begin base = 3; if (z) begin e.n_pcen = 2; e.pcs = 1; end end
         6'b000010: begin base = 3; e.n_pcen = 2; e.pcs = 2; end
         default:   e.n_ill = 1;
      endcase
      e.lat = base + fs + (mem_op ? ms : 0);
      if (base != 2) ret_model = (ret_model + 1) % (1 << CNT_W);
      e.ret = ret_model;
      exp_q.push_back(e);

      opcode = op; funct = fn; zero = z;
      for (int c = 0; c < e.lat; c++) begin
         if (c < fs)                                      cyc(1'b0);
         else if (c == fs)                                cyc(1'b1);
         else if (mem_op && c >= fs + 3 && c < fs + 3 + ms) cyc(1'b0);
         else if (mem_op && c == fs + 3 + ms)             cyc(1'b1);
         else                                             cyc(1'($urandom_range(0, 1)));
      end
   endtask

   // Monitor: accumulate observed activity per instruction, compare on return to FETCH.
   initial begin
      exp_t a, e;
      bit in_instr, prev_fetch, cur_fetch;
      in_instr = 0; prev_fetch = 0;
      a = '{default: 0};
      forever begin
         @(negedge clk);
         if (reset || !mon_en) begin
            in_instr = 0; prev_fetch = 0;
         end else begin
            cur_fetch = (state_o == 4'(FETCH));
            if (cur_fetch && !prev_fetch) begin
               if (in_instr) begin
                  if (exp_q.size() == 0) begin
                     chk("unexpected_instr", 1, 0);
                  end else begin
                     e = exp_q.pop_front();
                     chk("latency",   a.lat,    e.lat);
                     chk("retired",   int'(retired), e.ret);
                     chk("mem_req",   a.n_mreq, e.n_mreq);
                     chk("iord",      a.n_iord, e.n_iord);
                     chk("mem_write", a.n_mw,   e.n_mw);
                     chk("ir_write",  a.n_irw,  e.n_irw);
                     chk("pc_en",     a.n_pcen, e.n_pcen);
                     chk("pc_src",    a.pcs,    e.pcs);
                     chk("reg_write", a.n_rw,   e.n_rw);
                     chk("reg_dst",   a.dst,    e.dst);
                     chk("memto_reg", a.m2r,    e.m2r);
                     chk("illegal",   a.n_ill,  e.n_ill);
                     chk("alu_ctl",   a.alu,    e.alu);
                  end
               end
               a = '{default: 0};
               in_instr = 1;
            end
            a.lat++;
            if (mem_req)   a.n_mreq++;
            if (iord)      a.n_iord++;
            if (mem_write) a.n_mw++;
            if (ir_write)  a.n_irw++;
            if (illegal_op) a.n_ill++;
            if (pc_en) begin
               a.n_pcen++;
               if (!cur_fetch) a.pcs |= int'(pc_src);
            end
            if (reg_write) begin
               a.n_rw++; a.dst = int'(reg_dst); a.m2r = int'(memto_reg);
            end
            if (state_o == 4'(EXECUTE)) a.alu = int'(alu_control);
            prev_fetch = cur_fetch;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (n_chk=%0d)", n_chk);
      $fatal(1);
   end

   initial begin
      logic [5:0] ops[7];
      logic [5:0] fns[5];
      int k;
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      reset = 1'b1; mem_ready = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_state",    int'(state_o), 0);
      chk("rst_retired",  int'(retired), 0);
      chk("rst_illegal",  int'(illegal_op), 0);
      chk("rst_mem_req",  int'(mem_req), 0);
      chk("rst_ir_write", int'(ir_write), 0);
      chk("rst_pc_en",    int'(pc_en), 0);
      @(posedge clk); #1;
      reset = 1'b0; mon_en = 1'b1;

      issue(6'b100011, 6'b0, 1'b0, 0, 0);           // lw
      issue(6'b101011, 6'b0, 1'b0, 0, 3);           // sw, 3 stall cycles
      issue(6'b000100, 6'b0, 1'b1, 0, 0);           // beq taken
      issue(6'b000100, 6'b0, 1'b0, 0, 0);           // beq not taken
      issue(6'b000000, 6'b101010, 1'b0, 0, 0);      // slt
      issue(6'b000000, 6'b111111, 1'b0, 0, 0);      // bad funct
      issue(6'b111111, 6'b0, 1'b0, 0, 0);           // bad opcode
      for (int i = 0; i < 17; i++) issue(6'b000010, 6'b0, 1'b0, 0, 0);
      issue(6'b100011, 6'b0, 1'b0, 2, 2);
      issue(6'b001000, 6'b0, 1'b0, 1, 0);
      for (int i = 0; i < 80; i++) begin
         k = $urandom_range(0, 6);
         issue((k == 6) ? 6'($urandom_range(16, 63)) : ops[k],
               ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)],
               1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
      end
      cyc(1'b0);
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc(1'b0);
      chk("queue_drained", exp_q.size(), 0);
      mon_en = 1'b0;

      // Reset landing on a completing MEMWR cycle must suppress the write.
      opcode = 6'b101011;
      cyc(1'b1); cyc(1'b0); cyc(1'b0);
      mem_ready = 1'b1; reset = 1'b1;
      @(negedge clk);
      chk("rstwr_state",     int'(state_o), 5);
      chk("rstwr_mem_write", int'(mem_write), 0);
      chk("rstwr_mem_req",   int'(mem_req), 0);
      @(negedge clk);
      chk("rstwr_next",      int'(state_o), 0);
      chk("rstwr_retired",   int'(retired), 0);
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
